// File: rtl/alu_seq_divider.sv
// alu_seq_divider: multi-cycle restoring divider beside the combinational ALU.
// Divides an 8-bit product-width dividend by a 4-bit operand-width divisor,
// one quotient bit per cycle, MSB first, over a start/done handshake.
// The handshake outputs are registered one cycle behind the control state.
// As a result, busy is high for exactly DW cycles and done arrives DW+1
// cycles after the accepting edge.
module alu_seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;          // latched dividend, shifted left each step
  logic [VW-1:0] dvs_q, dvs_d;          // latched divisor
  logic [VW-1:0] part_q, part_d;        // partial remainder (always < divisor)
  logic [DW-1:0] quo_q, quo_d;          // quotient being assembled
  logic [CW-1:0] cnt_q, cnt_d;          // step counter
  logic          dbz_int_q, dbz_int_d;  // latched divisor was zero
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  // One restoring step: bring in the next dividend bit, trial-subtract the divisor.
  logic [VW:0] shifted;
  logic [VW:0] diff;
  logic        fits;

  always_comb begin
    shifted = {part_q, dvd_q[DW-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = (shifted >= {1'b0, dvs_q});
  end

  // Next-state, datapath and handshake-output logic.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    dbz_int_d   = dbz_int_q;
    busy_d      = (state_q == S_RUN);
    done_d      = (state_q == S_DONE);
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      S_RUN: begin
        part_d = VW'(fits ? diff : shifted);
        quo_d  = {quo_q[DW-2:0], fits};
        dvd_d  = {dvd_q[DW-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = S_DONE;
        end
      end
      default: begin  // S_IDLE, S_DONE: start may be accepted
        if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          part_d = '0;
          quo_d  = '0;
          cnt_d  = '0;
          dbz_d  = 1'b0;
          if (divisor == '0) begin
            state_d   = S_DONE;
            quo_d     = '1;
            dbz_int_d = 1'b1;
          end else begin
            state_d   = S_RUN;
            dbz_int_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
        // Publishing the finished result overrides the clear above, so the
        // flag always travels with its own done pulse.
        if (state_q == S_DONE) begin
          quotient_d  = quo_q;
          remainder_d = part_q;
          dbz_d       = dbz_int_q;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: datapath regs are reset too; outputs must read 0 after reset.
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      dbz_int_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      dbz_int_q   <= dbz_int_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Testbench for alu_seq_divider.
// Directed vectors come from a table, followed by hand-written multi-cycle
// corner cases and a sweep of every operand pair. Expected results come from
// plain integer division.
module tb_alu_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq_divider #(.DW(8), .VW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    int         bsy;
  } vec_t;

  vec_t vecs[8];

  // Advance one clock edge, then settle 1ns before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer division with the divide-by-zero rule.
  function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                output logic [7:0] q, output logic [3:0] r, output logic z,
                                output int lat, output int bsy);
    if (b == 0) begin
      q = 8'hFF; r = 4'd0; z = 1'b1; lat = 1; bsy = 0;
    end else begin
      q = 8'(int'(a) / int'(b));
      r = 4'(int'(a) % int'(b));
      z = 1'b0; lat = 9; bsy = 8;
    end
  endfunction

  // Issue one single-cycle start and collect the result, latency and busy count.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit scramble,
                        output int lat, output int bsy, output logic [7:0] q,
                        output logic [3:0] r, output logic z, output bit one_pulse);
    lat = -1; bsy = 0; q = '0; r = '0; z = 1'b0;
    dividend = a; divisor = b; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      if (scramble) begin
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
      end
      step();
      if (busy) bsy++;
      if (done) begin
        lat = k; q = quotient; r = remainder; z = div_by_zero;
      end
    end
    step();
    one_pulse = !done;
  endtask

  initial begin
    int         lat, bsy, cnt, d1, d2;
    logic [7:0] q, q1, q2, eq;
    logic [3:0] r, r1, r2, er;
    logic       z, ez;
    bit         onep;
    int         elat, ebsy;
    logic [11:0] idx, mask;

    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 9, 8};
    vecs[1] = '{8'd225, 4'd15, 8'd15,  4'd0, 1'b0, 9, 8};
    vecs[2] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9, 8};
    vecs[3] = '{8'd100, 4'd0,  8'hFF,  4'd0, 1'b1, 1, 0};
    vecs[4] = '{8'd9,   4'd3,  8'd3,   4'd0, 1'b0, 9, 8};
    vecs[5] = '{8'd7,   4'd8,  8'd0,   4'd7, 1'b0, 9, 8};
    vecs[6] = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 9, 8};
    vecs[7] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 9, 8};

    // Reset, with a start asserted alongside it that must be dropped.
    rst = 1'b1; start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    step(); step();
    rst = 1'b0; start = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done || busy) cnt++;
    end
    check("reset_start_dropped", cnt, 0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, lat, bsy, q, r, z, onep);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_r", i), r, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), z, vecs[i].z);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), bsy, vecs[i].bsy);
      check($sformatf("vec%0d_done_width", i), onep, 1);
    end

    // start held through RUN with operands changed mid-op; back-to-back accept.
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    step();
    dividend = 8'd50; divisor = 4'd3;
    d1 = -1; d2 = -1; q1 = '0; q2 = '0; r1 = '0; r2 = '0;
    for (int k = 1; k <= 25 && d2 < 0; k++) begin
      step();
      if (done) begin
        if (d1 < 0) begin
          d1 = k; q1 = quotient; r1 = remainder; start = 1'b0;
        end else begin
          d2 = k; q2 = quotient; r2 = remainder;
        end
      end
    end
    check("hold_first_done", d1, 9);
    check("hold_first_q", q1, 28);
    check("hold_first_r", r1, 4);
    check("b2b_second_done", d2, 18);
    check("b2b_second_q", q2, 16);
    check("b2b_second_r", r2, 2);
    step(); step();

    // Reset four cycles into RUN aborts the operation.
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("abort_was_busy", busy, 1);
    rst = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 4'd3;
    step();
    rst = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    run_op(8'd9, 4'd3, 1'b0, lat, bsy, q, r, z, onep);
    check("after_abort_q", q, 3);
    check("after_abort_r", r, 0);
    check("after_abort_latency", lat, 9);

    // Every operand pair, in a random order, with operand inputs scrambled mid-op.
    mask = 12'($urandom);
    for (int i = 0; i < 4096; i++) begin
      idx = 12'(i) ^ mask;
      model(idx[11:4], idx[3:0], eq, er, ez, elat, ebsy);
      run_op(idx[11:4], idx[3:0], 1'b1, lat, bsy, q, r, z, onep);
      check($sformatf("sweep_%0d/%0d_q", idx[11:4], idx[3:0]), q, eq);
      check($sformatf("sweep_%0d/%0d_r", idx[11:4], idx[3:0]), r, er);
      check($sformatf("sweep_%0d/%0d_dbz", idx[11:4], idx[3:0]), z, ez);
      check($sformatf("sweep_%0d/%0d_latency", idx[11:4], idx[3:0]), lat, elat);
      check($sformatf("sweep_%0d/%0d_busy", idx[11:4], idx[3:0]), bsy, ebsy);
      check($sformatf("sweep_%0d/%0d_done_width", idx[11:4], idx[3:0]), onep, 1);
      if (idx[3:0] != 0) begin
        check($sformatf("sweep_%0d/%0d_identity", idx[11:4], idx[3:0]),
              int'(q) * int'(idx[3:0]) + int'(r), int'(idx[11:4]));
        check($sformatf("sweep_%0d/%0d_r_lt_d", idx[11:4], idx[3:0]), r < idx[3:0], 1);
      end
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
